// File: rtl/recorder_ctrl_if.sv
// Key/status inputs and mode/timer outputs of the recorder sequencer.
// The controller takes the slave side; the key logic or bench takes the master side.
interface recorder_ctrl_if;
  logic       i_init_done;
  logic [1:0] i_init_phase;
  logic       i_key_play;
  logic       i_key_rec;
  logic       i_key_stop;
  logic       i_key_up;
  logic       i_key_down;
  logic       i_key_slow;
  logic       i_mem_full;

  logic [2:0] o_state;
  logic [4:0] o_timer;
  logic [1:0] o_speed_stat;
  logic [3:0] o_speed;
  logic [1:0] o_init_state;
  logic [1:0] o_rec_state;
  logic [4:0] o_rec_len;
  logic       o_play;
  logic       o_rec;
  logic       o_addr_clr;

  modport slave (
    input  i_init_done, i_init_phase, i_key_play, i_key_rec, i_key_stop,
           i_key_up, i_key_down, i_key_slow, i_mem_full,
    output o_state, o_timer, o_speed_stat, o_speed, o_init_state,
           o_rec_state, o_rec_len, o_play, o_rec, o_addr_clr
  );

  modport master (
    output i_init_done, i_init_phase, i_key_play, i_key_rec, i_key_stop,
           i_key_up, i_key_down, i_key_slow, i_mem_full,
    input  o_state, o_timer, o_speed_stat, o_speed, o_init_state,
           o_rec_state, o_rec_len, o_play, o_rec, o_addr_clr
  );
endinterface

// File: rtl/recorder_ctrl.sv
// Audio recorder sequencer: turns key pulses into mode, elapsed-seconds timer,
// playback speed and record-activity phase. All outputs are registered.
module recorder_ctrl #(
  parameter int CLK_HZ  = 12000000,
  parameter int MAX_SEC = 31
) (
  input  logic            i_clk,
  input  logic            i_rst,
  recorder_ctrl_if.slave  bus
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] QTR1     = CW'(CLK_HZ / 4);
  localparam logic [CW-1:0] QTR2     = CW'((CLK_HZ / 4) * 2);
  localparam logic [CW-1:0] QTR3     = CW'((CLK_HZ / 4) * 3);
  localparam logic [4:0]    MAX_T    = 5'(MAX_SEC);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_RECORD = 3'd3,
    ST_PAUSE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    timer_q, timer_d;
  logic [3:0]    speed_q, speed_d;
  logic [1:0]    speed_stat_q, speed_stat_d;
  logic          slow_mode_q, slow_mode_d;
  logic          from_rec_q, from_rec_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    slow_cnt_q, slow_cnt_d;
  logic [4:0]    rec_len_q, rec_len_d;
  logic [1:0]    rec_state_q, rec_state_d;
  logic [1:0]    init_state_q, init_state_d;
  logic          addr_clr_q, addr_clr_d;
  logic          play_q, play_d;
  logic          rec_q, rec_d;

  logic          key_stop, key_play, key_rec;
  logic          running, tick, speed_keys_ok;
  logic [5:0]    play_sum;

  // Stop outranks play, play outranks rec.
  assign key_stop = bus.i_key_stop;
  assign key_play = bus.i_key_play & ~bus.i_key_stop;
  assign key_rec  = bus.i_key_rec & ~bus.i_key_play & ~bus.i_key_stop;

  assign running       = (state_q == ST_PLAY) || (state_q == ST_RECORD);
  assign tick          = running && (tick_cnt_q == TICK_MAX);
  assign speed_keys_ok = (state_q == ST_IDLE) || (state_q == ST_PLAY) || (state_q == ST_PAUSE);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    speed_d     = speed_q;
    slow_mode_d = slow_mode_q;
    from_rec_d  = from_rec_q;
    tick_cnt_d  = tick_cnt_q;
    slow_cnt_d  = slow_cnt_q;
    rec_len_d   = rec_len_q;
    addr_clr_d  = 1'b0;
    play_sum    = '0;

    if (tick) begin
      tick_cnt_d = '0;
    end else if (running) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (bus.i_init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        timer_d = '0;
        if (key_play && (rec_len_q != 5'd0)) begin
          state_d    = ST_PLAY;
          addr_clr_d = 1'b1;
          tick_cnt_d = '0;
          slow_cnt_d = '0;
        end else if (key_rec) begin
          state_d    = ST_RECORD;
          addr_clr_d = 1'b1;
          tick_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        if (key_stop) begin
          state_d = ST_IDLE;
        end else begin
          if (key_play) begin
            state_d    = ST_PAUSE;
            from_rec_d = 1'b0;
          end
          // A tick on the pause cycle still counts; reaching the end wins over pause.
          if (tick) begin
            if (speed_q == 4'd1) begin
              play_sum = {1'b0, timer_q} + 6'd1;
            end else if (!slow_mode_q) begin
              play_sum = {1'b0, timer_q} + {2'b00, speed_q};
            end else if ({1'b0, slow_cnt_q} == (speed_q - 4'd1)) begin
              play_sum   = {1'b0, timer_q} + 6'd1;
              slow_cnt_d = '0;
            end else begin
              play_sum   = {1'b0, timer_q};
              slow_cnt_d = slow_cnt_q + 3'd1;
            end
            if (play_sum >= {1'b0, rec_len_q}) begin
              timer_d = rec_len_q;
              state_d = ST_IDLE;
            end else begin
              timer_d = play_sum[4:0];
            end
          end
        end
      end
      ST_RECORD: begin
        if (key_stop || bus.i_mem_full) begin
          state_d   = ST_IDLE;
          rec_len_d = timer_q;
        end else begin
          if (key_rec) begin
            state_d    = ST_PAUSE;
            from_rec_d = 1'b1;
          end
          if (tick) begin
            if (timer_q == MAX_T) begin
              state_d   = ST_IDLE;
              rec_len_d = MAX_T;
            end else begin
              timer_d = timer_q + 5'd1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (key_stop) begin
          state_d = ST_IDLE;
          if (from_rec_q) rec_len_d = timer_q;
        end else if (key_play && !from_rec_q) begin
          state_d = ST_PLAY;
        end else if (key_rec && from_rec_q) begin
          state_d = ST_RECORD;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Simultaneous up and down cancel; any accepted speed key restarts the slow divider.
    if (speed_keys_ok) begin
      if (bus.i_key_up ^ bus.i_key_down) begin
        slow_cnt_d = '0;
        if (bus.i_key_up && (speed_q != 4'd8))   speed_d = speed_q + 4'd1;
        if (bus.i_key_down && (speed_q != 4'd1)) speed_d = speed_q - 4'd1;
      end
      if (bus.i_key_slow) begin
        slow_mode_d = ~slow_mode_q;
        slow_cnt_d  = '0;
      end
    end
  end

  always_comb begin
    speed_stat_d = 2'd0;
    if (speed_d != 4'd1) speed_stat_d = slow_mode_d ? 2'd2 : 2'd1;

    // Record phase follows the tick counter so it stays in step across pauses.
    rec_state_d = 2'd0;
    if (state_d == ST_RECORD) begin
      if (tick_cnt_d >= QTR3)      rec_state_d = 2'd3;
      else if (tick_cnt_d >= QTR2) rec_state_d = 2'd2;
      else if (tick_cnt_d >= QTR1) rec_state_d = 2'd1;
    end

    init_state_d = (state_d == ST_INIT) ? bus.i_init_phase : 2'd0;
    play_d       = (state_d == ST_PLAY);
    rec_d        = (state_d == ST_RECORD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_INIT;
      timer_q      <= '0;
      speed_q      <= 4'd1;
      speed_stat_q <= 2'd0;
      slow_mode_q  <= 1'b0;
      from_rec_q   <= 1'b0;
      tick_cnt_q   <= '0;
      slow_cnt_q   <= '0;
      rec_len_q    <= '0;
      rec_state_q  <= 2'd0;
      init_state_q <= bus.i_init_phase;
      addr_clr_q   <= 1'b0;
      play_q       <= 1'b0;
      rec_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      speed_q      <= speed_d;
      speed_stat_q <= speed_stat_d;
      slow_mode_q  <= slow_mode_d;
      from_rec_q   <= from_rec_d;
      tick_cnt_q   <= tick_cnt_d;
      slow_cnt_q   <= slow_cnt_d;
      rec_len_q    <= rec_len_d;
      rec_state_q  <= rec_state_d;
      init_state_q <= init_state_d;
      addr_clr_q   <= addr_clr_d;
      play_q       <= play_d;
      rec_q        <= rec_d;
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_timer      = timer_q;
  assign bus.o_speed_stat = speed_stat_q;
  assign bus.o_speed      = speed_q;
  assign bus.o_init_state = init_state_q;
  assign bus.o_rec_state  = rec_state_q;
  assign bus.o_rec_len    = rec_len_q;
  assign bus.o_play       = play_q;
  assign bus.o_rec        = rec_q;
  assign bus.o_addr_clr   = addr_clr_q;

endmodule

// File: doc/recorder_ctrl.md
Name: recorder_ctrl

Overview:
Top-level sequencer for the audio recorder. It turns debounced key pulses and codec-init status into the system mode, the elapsed-seconds timer, the playback speed setting and the record-activity phase. These outputs drive both the seven-segment status display and the play/record datapath enables. The block sits between the key debouncers and the audio player/recorder/SRAM address logic.

Parameters:
CLK_HZ, 12000000, i_clk cycles per second of real time (benches use 4)
MAX_SEC, 31, longest recording in seconds; must be at most 31

Ports:
i_clk  in  1  system clock (12 MHz codec BCLK domain)
i_rst  in  1  synchronous reset, active-high
i_init_done  in  1  level; codec I2C initialisation finished
i_init_phase  in  2  phase of the codec-init sequencer, passed through
i_key_play  in  1  1-cycle pulse; play, pause or resume
i_key_rec  in  1  1-cycle pulse; record, pause or resume
i_key_stop  in  1  1-cycle pulse; stop
i_key_up  in  1  1-cycle pulse; speed +1
i_key_down  in  1  1-cycle pulse; speed -1
i_key_slow  in  1  1-cycle pulse; toggle fast/slow mode
i_mem_full  in  1  level; SRAM address at its end
o_state  out  3  0 INIT, 1 IDLE, 2 PLAY, 3 RECORD, 4 PAUSE
o_timer  out  5  audio position in seconds
o_speed_stat  out  2  0 normal, 1 fast, 2 slow
o_speed  out  4  speed factor, 1..8
o_init_state  out  2  equals i_init_phase in INIT, otherwise 0
o_rec_state  out  2  record activity phase, 0..3
o_rec_len  out  5  length of the last recording in seconds
o_play  out  1  high while in PLAY
o_rec  out  1  high while in RECORD
o_addr_clr  out  1  1-cycle pulse that restarts the SRAM address

Behaviour:
- Reset (sync, active-high, wins over every input). Outputs reset to: o_state=0, o_timer=0, o_speed_stat=0, o_speed=1, o_rec_state=0, o_rec_len=0, o_play=0, o_rec=0, o_addr_clr=0. Internal state also clears: tick counter=0, slow sub-counter=0, paused_from=PLAY, slow_mode=0. Reset mid-record discards the take.
- All outputs are registered. Each state change takes effect on the cycle after the key pulse.
- Key priority in the same cycle: stop > play > rec. If up and down arrive together, speed is unchanged.
- Tick counter: counts 0..CLK_HZ-1 only in PLAY and RECORD. It is frozen in PAUSE and cleared to 0 on any entry from IDLE. A "tick" is the cycle in which it wraps.
- INIT -> IDLE when i_init_done=1. All keys are ignored in INIT.
- IDLE:
  - play with o_rec_len!=0 -> PLAY; timer=0 and one o_addr_clr pulse. Play with o_rec_len=0 is ignored.
  - rec -> RECORD; timer=0 and one o_addr_clr pulse.
  - o_timer holds 0 in IDLE.
- PLAY:
  - play -> PAUSE, paused_from=PLAY.
  - stop -> IDLE.
  - Timer advance on each tick:
    - normal (speed=1): +1.
    - fast: +o_speed.
    - slow: +1 when the slow sub-counter equals o_speed-1 (sub-counter then wraps to 0); otherwise the sub-counter increments.
  - The timer saturates at o_rec_len. On the tick where the new value is >= o_rec_len, o_timer=o_rec_len and the next state is IDLE.
- RECORD:
  - rec -> PAUSE, paused_from=RECORD.
  - stop or i_mem_full -> IDLE with o_rec_len=o_timer.
  - Each tick: if o_timer==MAX_SEC -> IDLE with o_rec_len=MAX_SEC; else o_timer+1.
  - o_rec_state increments mod 4 every CLK_HZ/4 cycles. It is 0 outside RECORD.
  - Speed is always 1x while recording.
- PAUSE:
  - play resumes PLAY only if paused_from=PLAY.
  - rec resumes RECORD only if paused_from=RECORD.
  - Timer and counters are held; there is no o_addr_clr pulse on resume.
  - stop -> IDLE; if paused_from=RECORD, o_rec_len=o_timer.
- Speed keys act in IDLE, PLAY and PAUSE; they are ignored in INIT and RECORD.
  - up: speed = min(speed+1, 8).
  - down: speed = max(speed-1, 1).
  - slow toggles slow_mode.
  - o_speed_stat = 0 if speed=1, else 2 if slow_mode, else 1.
  - A speed change resets the slow sub-counter to 0.
- Enables: o_play = (state==PLAY) and o_rec = (state==RECORD), both registered alongside o_state.

Test Plan:
- Init: assert i_rst for 2 cycles with i_init_phase=2 -> o_state=0, o_init_state=2, o_speed=1. Raise i_init_done -> o_state=1 next cycle and o_init_state=0.
- Record/stop: CLK_HZ=4. Send rec, wait 12 cycles, send stop -> o_addr_clr pulses once, o_timer reaches 3, o_rec_len=3, o_state=1, and o_rec_state cycled 0,1,2,3,0...
- Fast play: with o_rec_len=3, press up twice (speed=3, stat=1), then play -> o_timer=3 after the first tick, then o_state=1.
- Slow play with pause: press down to speed=2 and toggle slow (stat=2), then play -> o_timer increments every 8 cycles. Pause for 20 cycles -> o_timer is frozen. Send rec while paused -> ignored. Send play -> resumes.
- Limits: record with i_mem_full asserted at o_timer=5 -> IDLE, o_rec_len=5. Separately, record to the 31 s limit -> o_rec_len=31. Pressing up 10 times -> o_speed=8.
- Priority: stop and play in the same cycle in PLAY -> IDLE. Up and down in the same cycle -> speed unchanged. i_rst during RECORD -> o_state=0, o_rec_len=0.
